// File: rtl/halfip_rf_seq.sv
// halfip_rf_seq: sequencer for the 16x32 half-pel interpolation register file.
// Loads 16 reference words into entries 0..15, then issues dual-port read pairs
// to the half-pel filter under a valid/ready pair handshake.
//
// Optional feature macro: HALFIP_VERT_EN
//   defined   -> mode honoured; mode=1 reads vertical pairs (k, k+4), 12 pairs
//   undefined -> mode ignored; horizontal pairs (k, k+1), 15 pairs
//
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   start, mode     begin a block (IDLE only); pair orientation latched at start
//   s_data/valid    upstream reference stream; s_ready high only while loading
//   rf_ip, rf_sel_i, rf_wr           register-file write port
//   rf_rd, rf_sel_o1, rf_sel_o2      register-file read-pair port
//   rf_en           rf_wr | rf_rd
//   pair_valid/ready/idx             pair handshake towards the filter
//   busy, done      activity flag and one-cycle completion pulse

module halfip_rf_seq #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] rf_ip,
    output logic [3:0]        rf_sel_i,
    output logic              rf_wr,
    output logic              rf_rd,
    output logic [3:0]        rf_sel_o1,
    output logic [3:0]        rf_sel_o2,
    output logic              rf_en,
    output logic              pair_valid,
    input  logic              pair_ready,
    output logic [3:0]        pair_idx,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        READ,
        DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wc_q, wc_d;
    logic [3:0] rc_q, rc_d;
    logic [3:0] o2_q, o2_d;
    logic       pv_q, pv_d;
    logic [3:0] idx_q, idx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic [3:0] n_pairs;
    logic [3:0] step;
    logic [3:0] start_step;

`ifdef HALFIP_VERT_EN
    logic mode_q, mode_d;

    assign n_pairs    = mode_q ? 4'd12 : 4'd15;
    assign step       = mode_q ? 4'd4 : 4'd1;
    assign start_step = mode ? 4'd4 : 4'd1;
`else
    logic unused_mode;

    assign unused_mode = mode;
    assign n_pairs     = 4'd15;
    assign step        = 4'd1;
    assign start_step  = 4'd1;
`endif

    always_comb begin
        state_d = state_q;
        wc_d    = wc_q;
        rc_d    = rc_q;
        o2_d    = o2_q;
        pv_d    = pv_q;
        idx_d   = idx_q;
`ifdef HALFIP_VERT_EN
        mode_d  = mode_q;
`endif
        s_ready = 1'b0;
        rf_wr   = 1'b0;
        rf_rd   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    wc_d    = 4'd0;
                    rc_d    = 4'd0;
                    o2_d    = start_step;
`ifdef HALFIP_VERT_EN
                    mode_d  = mode;
`endif
                end
            end
            LOAD: begin
                s_ready = 1'b1;
                rf_wr   = s_valid;
                if (s_valid) begin
                    // wc holds at 15 so the write index never wraps
                    if (wc_q == 4'd15) begin
                        state_d = READ;
                    end else begin
                        wc_d = wc_q + 4'd1;
                    end
                end
            end
            READ: begin
                // an unaccepted pair blocks new reads so Op1/Op2 stay stable
                rf_rd = (rc_q < n_pairs) && (!pv_q || pair_ready);
                if (rf_rd) begin
                    rc_d  = rc_q + 4'd1;
                    o2_d  = rc_q + 4'd1 + step;
                    pv_d  = 1'b1;
                    idx_d = rc_q;
                end else if (pair_ready) begin
                    pv_d = 1'b0;
                end
                if (pv_q && pair_ready && (idx_q == n_pairs - 4'd1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wc_q    <= 4'd0;
            rc_q    <= 4'd0;
            o2_q    <= 4'd0;
            pv_q    <= 1'b0;
            idx_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef HALFIP_VERT_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            wc_q    <= wc_d;
            rc_q    <= rc_d;
            o2_q    <= o2_d;
            pv_q    <= pv_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef HALFIP_VERT_EN
            mode_q  <= mode_d;
`endif
        end
    end

    assign rf_ip      = s_data;
    assign rf_sel_i   = wc_q;
    assign rf_sel_o1  = rc_q;
    assign rf_sel_o2  = o2_q;
    assign rf_en      = rf_wr | rf_rd;
    assign pair_valid = pv_q;
    assign pair_idx   = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule
